// File: rtl/gmsk_frame_sync.sv
// GMSK hard-decision bit recovery and sync-word frame synchroniser.
// Phase differences are integrated over one symbol per sample; a sync hit locks symbol timing.
module gmsk_frame_sync #(
    parameter int                    PW          = 9,
    parameter int                    OSR         = 8,
    parameter int                    SYNC_LEN    = 16,
    parameter logic [SYNC_LEN-1:0]   SYNC_WORD   = 16'hB5C3,
    parameter int                    MAXERR      = 1,
    parameter int                    PAYLOAD_LEN = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [PW-1:0]                   phase_in,
    input  logic                            phase_valid,
    output logic                            bit_out,
    output logic                            bit_valid,
    output logic                            sync_found,
    output logic [$clog2(SYNC_LEN+1)-1:0]   sync_err,
    output logic                            locked,
    output logic                            frame_done
);
    localparam int SW = PW + $clog2(OSR);
    localparam int HL = SYNC_LEN * OSR;
    localparam int FW = $clog2(HL + 1);
    localparam int EW = $clog2(SYNC_LEN + 1);
    localparam int YW = $clog2(OSR);
    localparam int CW = $clog2(PAYLOAD_LEN + 1);

    typedef enum logic [1:0] {IDLE, HUNT, LOCK} state_t;

    state_t                 state;
    logic [PW-1:0]          prev_phase;
    logic                   have_prev;
    logic signed [PW-1:0]   d_p0;
    logic                   vld_p0;
    logic signed [PW-1:0]   dly [OSR];
    logic signed [SW-1:0]   sum_p1;
    logic                   vld_p1;
    logic [HL-1:0]          hist;
    logic [FW-1:0]          fill;
    logic [YW-1:0]          sym_cnt;
    logic [CW-1:0]          pay_cnt;

    logic                   b_now;
    logic [HL-1:0]          hist_next;
    logic [SYNC_LEN-1:0]    cand;
    logic [EW-1:0]          err_now;
    logic [FW-1:0]          fill_next;

    function automatic logic signed [SW-1:0] sext(input logic signed [PW-1:0] v);
        return SW'(v);
    endfunction

    function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
        return (v == FW'(HL)) ? v : v + 1'b1;
    endfunction

    function automatic logic [EW-1:0] popcount(input logic [SYNC_LEN-1:0] v);
        logic [EW-1:0] c;
        c = '0;
        for (int i = 0; i < SYNC_LEN; i++) c = c + EW'(v[i]);
        return c;
    endfunction

    // S3 decision and candidate word, taken one symbol apart through the history
    always_comb begin
        b_now     = ~sum_p1[SW-1] && (sum_p1 != '0);
        hist_next = {hist[HL-2:0], b_now};
        cand      = '0;
        for (int k = 0; k < SYNC_LEN; k++) cand[k] = hist_next[k*OSR];
        err_now   = popcount(cand ^ SYNC_WORD);
        fill_next = sat_inc(fill);
    end

    always_ff @(posedge clk) begin
        sync_found <= 1'b0;
        bit_valid  <= 1'b0;
        frame_done <= 1'b0;
        if (rst || !start) begin
            state     <= IDLE;
            have_prev <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            sum_p1    <= '0;
            for (int i = 0; i < OSR; i++) dly[i] <= '0;
            hist      <= '0;
            fill      <= '0;
            sym_cnt   <= '0;
            pay_cnt   <= '0;
            bit_out   <= 1'b0;
            sync_err  <= '0;
            locked    <= 1'b0;
        end else if (state == IDLE) begin
            state <= HUNT;
        end else begin
            // S1: wrapped phase difference
            vld_p0 <= phase_valid;
            if (phase_valid) begin
                prev_phase <= phase_in;
                have_prev  <= 1'b1;
                d_p0       <= have_prev ? $signed(phase_in - prev_phase) : '0;
            end
            // S2: one-symbol sliding sum
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                sum_p1 <= sum_p1 + sext(d_p0) - sext(dly[OSR-1]);
                dly[0] <= d_p0;
                for (int i = 1; i < OSR; i++) dly[i] <= dly[i-1];
            end
            if (frame_done) locked <= 1'b0;
            // S3: history, sync search and payload timing
            if (vld_p1) begin
                hist <= hist_next;
                fill <= fill_next;
                case (state)
                    HUNT: begin
                        if (fill_next == FW'(HL) && err_now <= EW'(MAXERR)) begin
                            sync_found <= 1'b1;
                            sync_err   <= err_now;
                            sym_cnt    <= '0;
                            pay_cnt    <= '0;
                            locked     <= 1'b1;
                            state      <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (sym_cnt == YW'(OSR - 1)) begin
                            sym_cnt   <= '0;
                            bit_out   <= b_now;
                            bit_valid <= 1'b1;
                            pay_cnt   <= pay_cnt + 1'b1;
                            if (pay_cnt == CW'(PAYLOAD_LEN - 1)) begin
                                // stale history must not produce a sync right after the frame
                                frame_done <= 1'b1;
                                hist       <= '0;
                                fill       <= '0;
                                have_prev  <= 1'b0;
                                state      <= HUNT;
                            end
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
